// File: rtl/i2c_target.sv
// I2C target: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address and
// serves a byte-wide register file through an auto-incrementing pointer.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// ADDR       | shifting in address + R/W bit
// ADDR_ACK   | driving ACK for our address
// PTR        | shifting in register pointer
// PTR_ACK    | driving ACK for pointer byte
// WR_DATA    | shifting in a write data byte
// WR_ACK     | driving ACK for write data
// RD_DATA    | driving read data bits
// RD_ACK     | sampling master ACK/NACK
// WAIT_STOP  | not addressed / NACKed, ignore bus
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16,
  localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [7:0]       wr_data_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_p_q, sda_s1_q, sda_s2_q, sda_p_q;
  logic rise_q, fall_q, start_q, stop_q, bit_q;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             ph_q;
  logic             rw_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q;
  logic             sda_oe_q, busy_q, wr_valid_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [7:0]       wr_data_q;
  logic [7:0]       mem_q [MEM_DEPTH];

  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  assign rx_byte = {shift_q[6:0], bit_q};
  assign ptr_inc = ptr_q + PTR_W'(1);

  // Synchronizers idle high so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_p_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_p_q <= 1'b1;
      rise_q   <= 1'b0; fall_q   <= 1'b0;
      start_q  <= 1'b0; stop_q   <= 1'b0; bit_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;    scl_s2_q <= scl_s1_q; scl_p_q <= scl_s2_q;
      sda_s1_q <= sda_i;    sda_s2_q <= sda_s1_q; sda_p_q <= sda_s2_q;
      rise_q   <= scl_s2_q & ~scl_p_q;
      fall_q   <= ~scl_s2_q & scl_p_q;
      start_q  <= scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
      stop_q   <= scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
      bit_q    <= sda_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      ph_q       <= 1'b0;
      rw_q       <= 1'b0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      wr_data_q  <= 8'h00;
      mem_q      <= '{default: 8'h00};
    end else begin
      wr_valid_q <= 1'b0;
      if (start_q) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        ph_q     <= 1'b0;
        busy_q   <= 1'b1;
        sda_oe_q <= 1'b0;
      end else if (stop_q) begin
        state_q  <= S_IDLE;
        cnt_q    <= 3'd0;
        ph_q     <= 1'b0;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: if (rise_q) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ph_q    <= 1'b0;
              rw_q    <= bit_q;
              state_q <= (rx_byte[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
            end
          end
          // ph_q=0: ACK not yet driven; ph_q=1: ACK on bus until the next fall
          S_ADDR_ACK: if (fall_q) begin
            if (!ph_q) begin
              sda_oe_q <= 1'b1;
              ph_q     <= 1'b1;
              shift_q  <= mem_q[ptr_q];
            end else begin
              ph_q  <= 1'b0;
              cnt_q <= 3'd0;
              if (rw_q) begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
                state_q  <= S_RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_PTR;
              end
            end
          end
          S_PTR: if (rise_q) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_q   <= rx_byte[PTR_W-1:0];
              ph_q    <= 1'b0;
              state_q <= S_PTR_ACK;
            end
          end
          S_PTR_ACK, S_WR_ACK: if (fall_q) begin
            if (!ph_q) begin
              sda_oe_q <= 1'b1;
              ph_q     <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              ph_q     <= 1'b0;
              cnt_q    <= 3'd0;
              state_q  <= S_WR_DATA;
            end
          end
          S_WR_DATA: if (rise_q) begin
            shift_q <= rx_byte;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              mem_q[ptr_q] <= rx_byte;
              wr_valid_q   <= 1'b1;
              wr_ptr_q     <= ptr_q;
              wr_data_q    <= rx_byte;
              ptr_q        <= ptr_inc;
              ph_q         <= 1'b0;
              state_q      <= S_WR_ACK;
            end
          end
          // Entered on a fall, so a fall seen with cnt_q==0 follows the 8th rise
          S_RD_DATA: begin
            if (rise_q) begin
              cnt_q <= cnt_q + 3'd1;
            end else if (fall_q) begin
              if (cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                ph_q     <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            if (rise_q && !ph_q) begin
              ptr_q <= ptr_inc;
              if (!bit_q) begin
                shift_q <= mem_q[ptr_inc];
                ph_q    <= 1'b1;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end else if (fall_q && ph_q) begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
              cnt_q    <= 3'd0;
              ph_q     <= 1'b0;
              state_q  <= S_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_ptr_o   = wr_ptr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master with open-drain SDA, a byte-array
// reference model of the register file and a log of expected register writes.
module tb_i2c_target;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe_o, busy_o, wr_valid_o;
  logic [3:0] wr_ptr_o;
  logic [7:0] wr_data_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tb_mem [16];
  int          tb_ptr = 0;
  logic [11:0] exp_wv [256];
  int          exp_n = 0;
  int          wv_chk = 0;
  logic [7:0]  wbuf [8];

  logic [11:0] wv_log [256];
  int          wv_n = 0;
  int          oe_cnt = 0;

  assign sda_line = m_sda & ~sda_oe_o;

  i2c_target #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe_o),
    .busy_o     (busy_o),
    .wr_valid_o (wr_valid_o),
    .wr_ptr_o   (wr_ptr_o),
    .wr_data_o  (wr_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid_o) begin
      wv_log[wv_n[7:0]] <= {wr_ptr_o, wr_data_o};
      wv_n <= wv_n + 1;
    end
    if (sda_oe_o) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq(); wq();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); ack = sda_line; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq(); m_scl = 1'b1; wq(); d = {d[6:0], sda_line}; wq(); m_scl = 1'b0;
    end
    wq(); m_sda = nack; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
  endtask

  task automatic check_wv(input string tag);
    check({tag, " wr_valid count"}, wv_n, exp_n);
    for (int i = wv_chk; i < exp_n && i < wv_n; i++)
      check({tag, " wr_valid ptr/data"}, wv_log[i[7:0]], exp_wv[i[7:0]]);
    wv_chk = exp_n;
  endtask

  task automatic write_txn(input logic [7:0] p, input int n, input string tag);
    logic a;
    i2c_start();
    check({tag, " busy after START"}, busy_o, 1'b1);
    write_byte(8'hA0, a); check({tag, " addr ack"}, a, 1'b0);
    write_byte(p, a);     check({tag, " ptr ack"}, a, 1'b0);
    tb_ptr = p % 16;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a); check({tag, " data ack"}, a, 1'b0);
      tb_mem[tb_ptr] = wbuf[i];
      exp_wv[exp_n[7:0]] = {tb_ptr[3:0], wbuf[i]};
      exp_n++;
      tb_ptr = (tb_ptr + 1) % 16;
    end
    i2c_stop();
    check({tag, " busy after STOP"}, busy_o, 1'b0);
    check_wv(tag);
  endtask

  task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, a); check({tag, " addr ack"}, a, 1'b0);
      write_byte(p, a);     check({tag, " ptr ack"}, a, 1'b0);
      tb_ptr = p % 16;
      i2c_start();
    end
    write_byte(8'hA1, a); check({tag, " read addr ack"}, a, 1'b0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check({tag, " read data"}, d, tb_mem[tb_ptr]);
      tb_ptr = (tb_ptr + 1) % 16;
    end
    i2c_stop();
    check({tag, " busy after STOP"}, busy_o, 1'b0);
  endtask

  initial begin
    logic a;
    int   oe0, n;
    logic [7:0] p;

    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("reset sda_oe", sda_oe_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset wr_valid", wr_valid_o, 1'b0);
    check("reset wr_ptr", wr_ptr_o, 4'h0);
    check("reset wr_data", wr_data_o, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'h03, 2, "write");
    read_txn(1'b1, 8'h03, 2, "readback");
    read_txn(1'b0, 8'h00, 1, "ptr persist");

    oe0 = oe_cnt;
    i2c_start();
    check("mismatch busy after START", busy_o, 1'b1);
    write_byte(8'hB0, a); check("mismatch addr nack", a, 1'b1);
    write_byte(8'h55, a); check("mismatch data nack", a, 1'b1);
    i2c_stop();
    check("mismatch busy after STOP", busy_o, 1'b0);
    check("mismatch sda_oe cycles", oe_cnt - oe0, 0);
    check_wv("mismatch");

    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    write_txn(8'h0F, 2, "wrap");
    read_txn(1'b1, 8'h0F, 2, "wrap read");

    i2c_start();
    write_byte(8'hA0, a); check("abort addr ack", a, 1'b0);
    write_byte(8'h07, a); check("abort ptr ack", a, 1'b0);
    tb_ptr = 7;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    wq();
    i2c_stop();
    check("abort busy", busy_o, 1'b0);
    check_wv("abort");
    wbuf[0] = 8'(($urandom));
    write_txn(8'h07, 1, "post-abort");
    read_txn(1'b1, 8'h07, 1, "post-abort read");

    for (int it = 0; it < 8; it++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(p, n, "rand write");
      if (it[0]) read_txn(1'b0, 8'h00, 2, "rand cont read");
      read_txn(1'b1, p, n + 1, "rand read");
    end

    wbuf[0] = 8'h00;
    write_txn(8'h09, 1, "zero write");
    i2c_start();
    write_byte(8'hA0, a); write_byte(8'h09, a);
    i2c_start();
    write_byte(8'hA1, a); check("rst-read addr ack", a, 1'b0);
    m_sda = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0;
    end
    wq();
    check("rst-read driving bit3", sda_oe_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset sda_oe", sda_oe_o, 1'b0);
    check("async reset busy", busy_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wq();
    i2c_stop();
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    tb_ptr = 0;
    read_txn(1'b1, 8'h00, 16, "post-reset read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) controller: the responder end of the bus driven by the team's I2C master-side interface. Samples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address, and serves a byte-wide register file with an auto-incrementing pointer for writes and reads. SDA is open-drain: the block only pulls low. It sits under the testbench bus as the DUT target and later inside the SoC peripheral fabric.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address this target ACKs
- MEM_DEPTH, 16, register file depth in bytes (power of two, 2..256); PTR_W = $clog2(MEM_DEPTH)
- clk  in  1  system clock; the only clock; all logic on posedge
- rst_n  in  1  reset, asynchronous and active-low
- scl_i  in  1  SCL pin level (asynchronous to clk)
- sda_i  in  1  SDA pin level (asynchronous to clk)
- sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z)
- busy  out  1  high from START until STOP
- wr_valid  out  1  one-cycle pulse per register write
- wr_ptr  out  PTR_W  register index written (valid with wr_valid)
- wr_data  out  8  byte written (valid with wr_valid)

## Operation
- scl_i/sda_i pass through 2-flop synchronizers; edges detected on synchronized signals (scl_rise, scl_fall).
- START: synced SDA falls while synced SCL high -> ADDR, bit count cleared, busy=1. Accepted in every state (repeated START).
- STOP: synced SDA rises while synced SCL high -> IDLE, sda_oe=0, busy=0. Accepted in every state, mid-byte included; partial byte discarded.
- Bits sampled on scl_rise, MSB first; 3-bit counter, byte complete on 8th rise.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: byte[7:1]==SLAVE_ADDR -> ADDR_ACK; mismatch -> WAIT_STOP (no ACK, SDA never driven).
- ADDR_ACK: rw=0 -> PTR; rw=1 -> RD_DATA, shift reg loaded with mem[ptr].
- PTR: received byte[PTR_W-1:0] -> ptr; ACK; then WR_DATA.
- WR_DATA: on 8th bit mem[ptr]<=byte, wr_valid pulse with old ptr/data, ptr<=ptr+1 mod MEM_DEPTH; ACK; loop to WR_DATA.
- RD_DATA: drive sda_oe = ~shift[7] per bit; after 8 bits release, sample master ACK on 9th scl_rise: SDA low -> ptr+1, load mem[ptr+1], RD_DATA; SDA high (NACK) -> WAIT_STOP, ptr still incremented.
- Pointer persists across transactions (write-pointer then repeated-START read).
- WAIT_STOP: ignore bus until START or STOP.
- Reset: all mem bytes 8'h00, ptr 0, state IDLE.

## Timing
- Reset values: sda_oe=0, busy=0, wr_valid=0, wr_ptr=0, wr_data=0.
- Input latency: pin change visible to FSM 2 clk later; START/STOP/edge flags registered, 3 clk total.
- Bus requirement: SCL high and low phases each >= 4 clk; SDA stable >= 2 clk around scl_rise.
- ACK drive: sda_oe=1 one clk after the scl_fall that ends bit 8; released one clk after the next scl_fall (end of ACK bit).
- Read data: each bit asserted one clk after the preceding scl_fall (first bit after the address-ACK fall); held through the high phase.
- wr_valid: asserted the clk after the 8th scl_rise of a data byte, exactly 1 clk wide, independent of ACK.
- START and STOP detected in same cycle impossible (needs SDA edge each); START wins over bit sampling when coincident.
- rst_n async assert mid-transfer: sda_oe drops immediately (no clk needed); bus released.

## Test plan
- Write: START, 0xA0, ptr 0x03, 0x11, 0x22, STOP -> 4 ACKs; wr_valid twice (ptr 3/0x11, ptr 4/0x22); ptr=5.
- Readback: START, 0xA0, ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK, NACK), STOP -> 0x11, 0x22 on SDA; busy low after STOP.
- Mismatch: START, 0xB0, 0x55, STOP -> sda_oe never asserted, no wr_valid, busy 1->0.
- Wrap: ptr 0x0F, write 0xAA, 0xBB -> mem[15]=0xAA, mem[0]=0xBB; read from 0x0F returns 0xAA, 0xBB.
- Abort: STOP after 4 data bits of a write -> no wr_valid, IDLE; next full write accepted normally.
- Reset mid-read: rst_n low while driving bit 3 of 0x00 -> sda_oe=0 same cycle; all mem reads 0x00 afterward.
